// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode/funct constants, ALU op codes and the decode-stage dispatch helper.
package mc_defs;

    typedef enum logic [3:0] {
        ST_IF  = 4'd0,  ST_ID  = 4'd1,  ST_MA  = 4'd2,  ST_MR  = 4'd3,
        ST_LW  = 4'd4,  ST_MW  = 4'd5,  ST_RX  = 4'd6,  ST_RW  = 4'd7,
        ST_BR  = 4'd8,  ST_J   = 4'd9,  ST_IX  = 4'd10, ST_IW  = 4'd11,
        ST_LUI = 4'd12, ST_JR  = 4'd13, ST_JAL = 4'd14, ST_ERR = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ST_ERR doubles as the "unknown opcode" marker for the decode stage.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] func);
        case (op)
            OP_LW, OP_SW:                           return ST_MA;
            OP_R:                                   return (func == FN_JR) ? ST_JR : ST_RX;
            OP_BEQ, OP_BNE:                         return ST_BR;
            OP_J:                                   return ST_J;
            OP_JAL:                                 return ST_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI:                                return ST_IX;
            OP_LUI:                                 return ST_LUI;
            default:                                return ST_ERR;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// ALU operation decoder: picks ALU_Control from the current state, opcode
// and funct, and flags an unsupported funct while executing an R-type.
module mc_alu_dec
    import mc_defs::*;
(
    input  logic [3:0] state,
    input  logic [5:0] OP,
    input  logic [5:0] Func,
    output logic [2:0] alu_ctrl,
    output logic       bad_funct
);

    always_comb begin
        alu_ctrl  = ALU_ADD;
        bad_funct = 1'b0;
        case (state)
            ST_RX: begin
                case (Func)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_XOR:  alu_ctrl = ALU_XOR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_SRL:  alu_ctrl = ALU_SRL;
                    default: bad_funct = 1'b1;
                endcase
            end
            ST_BR: alu_ctrl = ALU_SUB;
            ST_IX: begin
                case (OP)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_XORI: alu_ctrl = ALU_XOR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/
// write-back and drives the shared datapath's selects and enables.
//
// state  | meaning
// IF     | fetch, wait for MIO_ready, load IR, PC+4
// ID     | decode, branch target into ALUOut
// MA     | memory address compute
// MR/LW  | load read (waits on bus) / load write-back
// MW     | store write (waits on bus)
// RX/RW  | R-type execute / write-back
// BR     | branch compare and conditional PC load
// J/JR   | jump to target / to rs
// IX/IW  | I-type execute / write-back
// LUI    | upper-immediate write-back
// JAL    | link $31 and jump
// ERR    | parked on illegal opcode, reset only
module mc_ctrl
    import mc_defs::*;
#(
    parameter int ST_W            = 4,
    parameter bit HANG_ON_ILLEGAL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      OP,
    input  logic [5:0]      Func,
    input  logic            Zero,
    input  logic            MIO_ready,
    output logic            PC_en,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSource,
    output logic [2:0]      ALU_Control,
    output logic            CPU_MIO,
    output logic [ST_W-1:0] state_out,
    output logic            illegal
);

    state_t     state;
    state_t     id_target;
    logic [2:0] alu_ctrl;
    logic       bad_funct;

    assign id_target = decode_target(OP, Func);
    assign state_out = ST_W'(state);

    mc_alu_dec u_alu_dec (
        .state     (state),
        .OP        (OP),
        .Func      (Func),
        .alu_ctrl  (alu_ctrl),
        .bad_funct (bad_funct)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IF;
        end else begin
            case (state)
                ST_IF:  if (MIO_ready) state <= ST_ID;
                ST_ID: begin
                    if (id_target != ST_ERR)  state <= id_target;
                    else if (HANG_ON_ILLEGAL) state <= ST_ERR;
                    else                      state <= ST_IF;
                end
                ST_MA:  state <= (OP == OP_SW) ? ST_MW : ST_MR;
                ST_MR:  if (MIO_ready) state <= ST_LW;
                ST_MW:  if (MIO_ready) state <= ST_IF;
                ST_RX:  state <= bad_funct ? ST_IF : ST_RW;
                ST_IX:  state <= ST_IW;
                ST_ERR: state <= ST_ERR;
                default: state <= ST_IF;
            endcase
        end
    end

    // Outputs are decoded from the state register (plus Zero / MIO_ready
    // where the handshake needs them) and forced quiet while reset is high.
    always_comb begin
        PC_en       = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 2'b00;
        RegDst      = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALU_Control = 3'b000;
        CPU_MIO     = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            ALU_Control = alu_ctrl;
            case (state)
                ST_IF: begin
                    MemRead = 1'b1;
                    CPU_MIO = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MIO_ready;
                    PC_en   = MIO_ready;
                end
                ST_ID: begin
                    ALUSrcB = 2'b11;
                    illegal = (id_target == ST_ERR);
                end
                ST_MA: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ST_MR: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    CPU_MIO = 1'b1;
                end
                ST_LW: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                ST_MW: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    CPU_MIO  = 1'b1;
                end
                ST_RX: begin
                    ALUSrcA = 1'b1;
                    illegal = bad_funct;
                end
                ST_RW: begin
                    RegDst   = 2'b01;
                    RegWrite = 1'b1;
                end
                ST_BR: begin
                    ALUSrcA  = 1'b1;
                    PCSource = 2'b01;
                    PC_en    = (OP == OP_BEQ) ? Zero : ~Zero;
                end
                ST_J: begin
                    PCSource = 2'b10;
                    PC_en    = 1'b1;
                end
                ST_IX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ST_IW:  RegWrite = 1'b1;
                ST_LUI: begin
                    MemtoReg = 2'b11;
                    RegWrite = 1'b1;
                end
                ST_JR: begin
                    PCSource = 2'b11;
                    PC_en    = 1'b1;
                end
                ST_JAL: begin
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                    PCSource = 2'b10;
                    PC_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit; sequences the shared single-ALU/single-memory datapath through fetch, decode, execute, memory and write-back cycles.
- Decodes OP/Func into per-cycle datapath controls: mux selects, write enables, ALU operation.
- Sits between the instruction register and the datapath; the memory/IO bus is shared with other masters and handshaked via MIO_ready.
- The slt result path (1-bit flag zero-extended to 32 bits) is selected by ALU_Control.

Parameters:
- ST_W, 4, state register width.
- HANG_ON_ILLEGAL, 0, 1 = stay in ST_ERR on an unknown opcode; 0 = return to ST_IF.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- OP  in  6  IR[31:26].
- Func  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, valid in the cycle ALU_Control is driven.
- MIO_ready  in  1  memory/IO ready; a memory state completes only when this is 1.
- PC_en  out  1  PC write enable (unconditional or branch-resolved).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load enable.
- MemtoReg  out  2  register write data: 00 ALUOut, 01 MDR, 10 PC (jal), 11 {imm,16'h0} (lui).
- RegDst  out  2  destination register: 00 rt, 01 rd, 10 $31.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B operand: 00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm << 2.
- PCSource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr).
- ALU_Control  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
- CPU_MIO  out  1  bus request; high in every memory-access state.
- state_out  out  ST_W  current state, for debug display.
- illegal  out  1  one-cycle pulse on an unknown opcode or funct.

Behaviour:
- Reset: clk is the single clock; reset is asynchronous and active-high.
  - While reset is high, state = ST_IF (0).
  - While reset is high, every enable/strobe output is 0: PC_en, MemRead, MemWrite, IRWrite, RegWrite, CPU_MIO, illegal.
  - All selects are 0 while reset is high.
  - A reset mid-instruction abandons the instruction with no partial register write.
- Moore outputs decoded from the registered state. Exceptions: PC_en in ST_BR depends on Zero; the IF handshake term depends on MIO_ready.
- States and transitions:
  - ST_IF(0): MemRead=1, CPU_MIO=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00.
    - Wait while MIO_ready=0, with IRWrite=0 and PC_en=0.
    - When MIO_ready=1: IRWrite=1, PC_en=1, go to ST_ID.
  - ST_ID(1): ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Branch by OP:
    - lw/sw -> ST_MA
    - R-type -> ST_RX
    - beq/bne -> ST_BR
    - j -> ST_J
    - jal -> ST_JAL
    - addi/andi/ori/xori/slti -> ST_IX
    - lui -> ST_LUI
    - jr (R-type, Func 001000) -> ST_JR
    - otherwise -> illegal=1, next ST_IF (or ST_ERR if HANG_ON_ILLEGAL).
  - ST_MA(2): ALUSrcA=1, ALUSrcB=10, add; lw -> ST_MR, sw -> ST_MW.
  - ST_MR(3): IorD=1, MemRead=1, CPU_MIO=1; hold until MIO_ready=1, then -> ST_LW.
  - ST_LW(4): RegDst=00, MemtoReg=01, RegWrite=1; -> ST_IF.
  - ST_MW(5): IorD=1, MemWrite=1, CPU_MIO=1; hold until MIO_ready=1, then -> ST_IF.
    - MemWrite stays asserted and stable while waiting.
  - ST_RX(6): ALUSrcA=1, ALUSrcB=00, ALU_Control from Func:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl.
    - Any other Func -> illegal, -> ST_IF.
    - Otherwise -> ST_RW.
  - ST_RW(7): RegDst=01, MemtoReg=00, RegWrite=1; -> ST_IF.
  - ST_BR(8): ALUSrcA=1, ALUSrcB=00, sub, PCSource=01.
    - PC_en = Zero for beq, ~Zero for bne.
    - -> ST_IF.
  - ST_J(9): PCSource=10, PC_en=1; -> ST_IF.
  - ST_IX(10): ALUSrcA=1, ALUSrcB=10; ALU op: add (addi), and, or, xor, slt (slti); -> ST_IW.
  - ST_IW(11): RegDst=00, MemtoReg=00, RegWrite=1; -> ST_IF.
  - ST_LUI(12): RegDst=00, MemtoReg=11, RegWrite=1; -> ST_IF.
  - ST_JR(13): PCSource=11, PC_en=1; -> ST_IF.
  - ST_JAL(14): RegDst=10, MemtoReg=10, RegWrite=1, PCSource=10, PC_en=1; -> ST_IF.
    - PC already holds PC+4, so $31 receives the return address.
  - ST_ERR(15): all enables 0; exit only by reset.
- Latency in cycles, excluding wait states:
  - lw 5.
  - sw, R-type, I-type ALU 4.
  - beq/bne, j, jr, jal, lui 3.
- MIO_ready is sampled only in IF/MR/MW; ignored elsewhere.
- No register write or PC update occurs in any wait cycle.

Decomposition:
- Shared package mc_defs:
  - state encodings ST_*;
  - opcode constants (OP_R 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_J 000010, OP_JAL 000011, OP_ADDI 001000, OP_SLTI 001010, OP_ANDI 001100, OP_ORI 001101, OP_XORI 001110, OP_LUI 001111);
  - Func constants;
  - ALU op codes.
- One sub-module: mc_alu_dec, a combinational decoder (state, OP, Func) -> ALU_Control and illegal-funct flag.

Test Plan:
- Reset asserted mid-ST_MR: state_out drops to 0 asynchronously, RegWrite=0. After release, IF restarts with MemRead=1.
- lw with MIO_ready=1 throughout: states 0,1,2,3,4,0. Exactly one RegWrite pulse with MemtoReg=01 and RegDst=00.
- sw with MIO_ready low for 3 cycles in ST_MW: MemWrite held for 4 cycles, one transition to ST_IF, RegWrite never 1.
- beq Zero=1 -> PC_en=1 in ST_BR. bne Zero=1 -> PC_en=0. Both show PCSource=01 and ALU_Control=110.
- R-type Func 101010 -> ALU_Control=111 in ST_RX, then RegDst=01 with RegWrite=1. Func 111111 -> illegal pulse, no RegWrite.
- jal: ST_JAL asserts RegDst=10, MemtoReg=10, RegWrite=1, PC_en=1, PCSource=10 in the same cycle. Total 3 cycles.
